decode_queue: RTL and testbench



---
 rtl/decode_queue_pkg.sv | 94 +++++++++
 rtl/decode_queue_lane.sv | 127 ++++++++++++
 rtl/decode_queue.sv | 83 ++++++++
 tb/tb_decode_queue.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_queue_pkg.sv
// Shared RV32I decode types: opcode/funct7 constants, ALU selects,
// fetch->decode and decode->dispatch stage bundles, funct3 helpers.
package decode_queue_pkg;

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_REG   = 7'b0110011;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef enum logic [4:0] {
      alu_op_none,
      alu_add, alu_sub, alu_sll, alu_slt, alu_sltu,
      alu_xor, alu_srl, alu_sra, alu_or, alu_and,
      alu_mul, alu_mulh, alu_mulhsu, alu_mulhu,
      alu_div, alu_divu, alu_rem, alu_remu
   } alu_ops_t;

   typedef enum logic [1:0] {
      m1_rs1_out, m1_pc_out, m1_no_out
   } alu_m1_sel_t;

   typedef enum logic {
      m2_rs2_out, m2_imm_out
   } alu_m2_sel_t;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [63:0] order;
      logic        valid;
   } if_id_stage_reg_t;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [63:0] order;
      logic [4:0]  rs1_addr;
      logic [4:0]  rs2_addr;
      logic [4:0]  rd_addr;
      logic [31:0] imm;
      alu_ops_t    aluop;
      alu_m1_sel_t alu_m1_sel;
      alu_m2_sel_t alu_m2_sel;
      logic        regf_we;
      logic        is_branch;
      logic        is_jump;
      logic        mem_re;
      logic        mem_we;
      logic        illegal;
      logic        is_muldiv;
   } id_dis_stage_reg_t;

   // alt picks sub over add (funct3 000) and sra over srl (funct3 101)
   function automatic alu_ops_t base_alu(input logic [2:0] f3,
                                         input logic       alt);
      alu_ops_t op;
      case (f3)
         3'b000:  op = alt ? alu_sub : alu_add;
         3'b001:  op = alu_sll;
         3'b010:  op = alu_slt;
         3'b011:  op = alu_sltu;
         3'b100:  op = alu_xor;
         3'b101:  op = alt ? alu_sra : alu_srl;
         3'b110:  op = alu_or;
         default: op = alu_and;
      endcase
      return op;
   endfunction

   function automatic alu_ops_t muldiv_alu(input logic [2:0] f3);
      alu_ops_t op;
      case (f3)
         3'b000:  op = alu_mul;
         3'b001:  op = alu_mulh;
         3'b010:  op = alu_mulhsu;
         3'b011:  op = alu_mulhu;
         3'b100:  op = alu_div;
         3'b101:  op = alu_divu;
         3'b110:  op = alu_rem;
         default: op = alu_remu;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/decode_queue_lane.sv
// decode_lane: combinational RV32I decoder, one fetched instruction in,
// one dispatch bundle out. inst_i: fetch bundle; dec_o: decoded bundle.
// DECODE_MULDIV_EN: decode funct7=0000001 on OP as RV32M.
module decode_lane
   import decode_queue_pkg::*;
(
   input  if_id_stage_reg_t  inst_i,
   output id_dis_stage_reg_t dec_o
);

   logic [31:0] ir;
   logic [6:0]  opc;
   logic [6:0]  f7;
   logic [2:0]  f3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic        bad;
   logic        unused_valid;

   assign ir  = inst_i.inst;
   assign opc = ir[6:0];
   assign f3  = ir[14:12];
   assign f7  = ir[31:25];

   assign imm_i = {{21{ir[31]}}, ir[30:20]};
   assign imm_s = {{21{ir[31]}}, ir[30:25], ir[11:7]};
   assign imm_b = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
   assign imm_u = {ir[31:12], 12'd0};
   assign imm_j = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};

   // queue only holds valid entries; the flag carries no decode info
   assign unused_valid = inst_i.valid;

   always_comb begin
      dec_o            = '0;
      bad              = 1'b0;
      dec_o.inst       = ir;
      dec_o.pc         = inst_i.pc;
      dec_o.order      = inst_i.order;
      dec_o.rs1_addr   = ir[19:15];
      dec_o.rs2_addr   = ir[24:20];
      dec_o.rd_addr    = ir[11:7];
      dec_o.aluop      = alu_op_none;
      dec_o.alu_m1_sel = m1_rs1_out;
      dec_o.alu_m2_sel = m2_rs2_out;
      unique case (1'b1)
         (opc == OP_LUI): begin
            dec_o.imm        = imm_u;
            dec_o.alu_m1_sel = m1_no_out;
            dec_o.alu_m2_sel = m2_imm_out;
            dec_o.aluop      = alu_add;
            dec_o.regf_we    = 1'b1;
         end
         (opc == OP_AUIPC): begin
            dec_o.imm        = imm_u;
            dec_o.alu_m1_sel = m1_pc_out;
            dec_o.alu_m2_sel = m2_imm_out;
            dec_o.aluop      = alu_add;
            dec_o.regf_we    = 1'b1;
         end
         (opc == OP_IMM): begin
            dec_o.imm        = imm_i;
            dec_o.alu_m2_sel = m2_imm_out;
            // funct7[5] only matters for right shifts; addi has no sub
            dec_o.aluop      = base_alu(f3, (f3 == 3'b101) & ir[30]);
            dec_o.regf_we    = 1'b1;
         end
         (opc == OP_REG): begin
            dec_o.regf_we = 1'b1;
            if (f7 == F7_BASE) begin
               dec_o.aluop = base_alu(f3, 1'b0);
            end else if (f7 == F7_ALT &&
                         (f3 == 3'b000 || f3 == 3'b101)) begin
               dec_o.aluop = base_alu(f3, 1'b1);
`ifdef DECODE_MULDIV_EN
            end else if (f7 == F7_MULDIV) begin
               dec_o.aluop     = muldiv_alu(f3);
               dec_o.is_muldiv = 1'b1;
`endif
            end else begin
               bad = 1'b1;
            end
         end
         (opc == OP_JAL): begin
            dec_o.imm     = imm_j;
            dec_o.is_jump = 1'b1;
            dec_o.regf_we = 1'b1;
         end
         (opc == OP_JALR): begin
            dec_o.imm     = imm_i;
            dec_o.is_jump = 1'b1;
            dec_o.regf_we = 1'b1;
         end
         (opc == OP_BR): begin
            dec_o.imm       = imm_b;
            dec_o.is_branch = 1'b1;
            dec_o.rd_addr   = 5'd0;
         end
         (opc == OP_LOAD): begin
            dec_o.imm        = imm_i;
            dec_o.alu_m2_sel = m2_imm_out;
            dec_o.aluop      = alu_add;
            dec_o.mem_re     = 1'b1;
            dec_o.regf_we    = 1'b1;
         end
         (opc == OP_STORE): begin
            dec_o.imm        = imm_s;
            dec_o.alu_m2_sel = m2_imm_out;
            dec_o.aluop      = alu_add;
            dec_o.mem_we     = 1'b1;
            dec_o.rd_addr    = 5'd0;
         end
         default: bad = 1'b1;
      endcase
      if (bad) begin
         dec_o.illegal   = 1'b1;
         dec_o.regf_we   = 1'b0;
         dec_o.mem_re    = 1'b0;
         dec_o.mem_we    = 1'b0;
         dec_o.is_branch = 1'b0;
         dec_o.is_jump   = 1'b0;
         dec_o.is_muldiv = 1'b0;
         dec_o.aluop     = alu_op_none;
      end
      if (dec_o.rd_addr == 5'd0) dec_o.regf_we = 1'b0;
   end

endmodule

// File: rtl/decode_queue.sv
// decode_queue: DEPTH-entry circular buffer between fetch and dispatch,
// presenting up to DECODE_WIDTH decoded instructions per cycle in order.
// Ports: clk, rst (async high), flush, enq_valid/enq_data/enq_ready
// (fetch side), out_valid/out_data/dis_accept (dispatch side), occupancy.
// DECODE_MULDIV_EN: enables RV32M decode in every lane.
module decode_queue
   import decode_queue_pkg::*;
#(
   parameter int unsigned DEPTH        = 8,
   parameter int unsigned DECODE_WIDTH = 2
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    flush,
   input  logic                                    enq_valid,
   input  if_id_stage_reg_t                        enq_data,
   output logic                                    enq_ready,
   output logic [DECODE_WIDTH-1:0]                 out_valid,
   output id_dis_stage_reg_t [DECODE_WIDTH-1:0]    out_data,
   input  logic [$clog2(DECODE_WIDTH+1)-1:0]       dis_accept,
   output logic [$clog2(DEPTH+1)-1:0]              occupancy
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic [CW-1:0]    acc_w, deq_n;
   logic             enq_fire;
   if_id_stage_reg_t mem_q [DEPTH];

   // full is judged on registered count only: no credit from dequeue
   assign enq_ready = (count_q != CW'(DEPTH));
   assign enq_fire  = enq_valid & enq_ready & enq_data.valid;
   assign acc_w     = CW'(dis_accept);
   assign deq_n     = (acc_w > count_q) ? count_q : acc_w;
   assign occupancy = count_q;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         // DEPTH is a power of two, so truncation is the modulo wrap
         head_d  = head_q + deq_n[PW-1:0];
         tail_d  = tail_q + PW'(enq_fire);
         count_d = count_q + CW'(enq_fire) - deq_n;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (enq_fire && !flush) mem_q[tail_q] <= enq_data;
   end

   for (genvar i = 0; i < int'(DECODE_WIDTH); i++) begin : g_lane
      logic [PW-1:0] idx;
      assign idx          = head_q + PW'(i);
      assign out_valid[i] = (CW'(i) < count_q);
      decode_lane u_lane (
         .inst_i (mem_q[idx]),
         .dec_o  (out_data[i])
      );
   end

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: directed steps plus random traffic, checked
// against an encoder-driven queue model of expected decode results.
module tb_decode_queue;
   import decode_queue_pkg::*;

   localparam int DEPTH = 8;
   localparam int DW    = 2;
   localparam int AW    = $clog2(DW+1);
   localparam int CW    = $clog2(DEPTH+1);

   localparam int K_LUI = 0, K_AUIPC = 1, K_IMM = 2, K_REG = 3;
   localparam int K_JAL = 4, K_JALR = 5, K_BR = 6, K_LOAD = 7;
   localparam int K_STORE = 8, K_MULDIV = 9, K_BAD = 10;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [63:0] order;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] imm;
      alu_ops_t    aluop;
      alu_m1_sel_t m1;
      alu_m2_sel_t m2;
      logic we, br, jmp, mre, mwe, ill, md;
      logic c_rs1, c_rs2, c_rd, c_imm, c_alu, c_m1, c_m2;
   } exp_t;

   logic clk = 1'b0;
   logic rst, flush, enq_valid, enq_ready;
   if_id_stage_reg_t enq_data;
   logic [DW-1:0] out_valid;
   id_dis_stage_reg_t [DW-1:0] out_data;
   logic [AW-1:0] dis_accept;
   logic [CW-1:0] occupancy;

   int checks = 0;
   int failures = 0;
   logic [63:0] ord_ctr = 64'd0;
   exp_t mdl[$];

   always #5 clk = ~clk;

   decode_queue #(.DEPTH(DEPTH), .DECODE_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .enq_valid(enq_valid), .enq_data(enq_data),
      .enq_ready(enq_ready), .out_valid(out_valid),
      .out_data(out_data), .dis_accept(dis_accept),
      .occupancy(occupancy)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic alu_ops_t ref_alu(input logic [2:0] f3,
                                        input logic alt);
      case (f3)
         3'd0: return alt ? alu_sub : alu_add;
         3'd1: return alu_sll;
         3'd2: return alu_slt;
         3'd3: return alu_sltu;
         3'd4: return alu_xor;
         3'd5: return alt ? alu_sra : alu_srl;
         3'd6: return alu_or;
         default: return alu_and;
      endcase
   endfunction

   function automatic alu_ops_t ref_md(input logic [2:0] f3);
      case (f3)
         3'd0: return alu_mul;
         3'd1: return alu_mulh;
         3'd2: return alu_mulhsu;
         3'd3: return alu_mulhu;
         3'd4: return alu_div;
         3'd5: return alu_divu;
         3'd6: return alu_rem;
         default: return alu_remu;
      endcase
   endfunction

   // Encodes an instruction from its fields and records what dispatch
   // must see; v is the intended immediate value.
   function automatic exp_t enc(input int kind, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [2:0] f3, input logic alt,
                                input logic [31:0] v);
      exp_t e;
      logic [31:0] w;
      e = '0;
      e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.c_rd = 1'b1;
      case (kind)
         K_LUI, K_AUIPC: begin
            w = v & 32'hFFFF_F000;
            e.inst = {w[31:12], rd, (kind == K_LUI) ? 7'h37 : 7'h17};
            e.imm = w; e.c_imm = 1'b1;
            e.aluop = alu_add; e.c_alu = 1'b1;
            e.m1 = (kind == K_LUI) ? m1_no_out : m1_pc_out;
            e.m2 = m2_imm_out; e.c_m1 = 1'b1; e.c_m2 = 1'b1;
            e.we = 1'b1;
         end
         K_IMM: begin
            if (f3 == 3'b001) w = {27'd0, v[4:0]};
            else if (f3 == 3'b101) w = {21'd0, alt, 5'd0, v[4:0]};
            else w = v;
            e.inst = {w[11:0], rs1, f3, rd, 7'h13};
            e.imm = w; e.c_imm = 1'b1;
            e.aluop = ref_alu(f3, (f3 == 3'b101) && alt); e.c_alu = 1'b1;
            e.m1 = m1_rs1_out; e.m2 = m2_imm_out;
            e.c_m1 = 1'b1; e.c_m2 = 1'b1; e.c_rs1 = 1'b1;
            e.we = 1'b1;
         end
         K_REG: begin
            e.inst = {alt ? 7'h20 : 7'h00, rs2, rs1, f3, rd, 7'h33};
            e.aluop = ref_alu(f3, alt); e.c_alu = 1'b1;
            e.m1 = m1_rs1_out; e.m2 = m2_rs2_out;
            e.c_m1 = 1'b1; e.c_m2 = 1'b1;
            e.c_rs1 = 1'b1; e.c_rs2 = 1'b1;
            e.we = 1'b1;
         end
         K_JAL: begin
            w = v & ~32'd1;
            e.inst = {w[20], w[10:1], w[11], w[19:12], rd, 7'h6F};
            e.imm = w; e.c_imm = 1'b1; e.jmp = 1'b1; e.we = 1'b1;
         end
         K_JALR: begin
            e.inst = {v[11:0], rs1, 3'b000, rd, 7'h67};
            e.imm = v; e.c_imm = 1'b1; e.c_rs1 = 1'b1;
            e.jmp = 1'b1; e.we = 1'b1;
         end
         K_BR: begin
            w = v & ~32'd1;
            e.inst = {w[12], w[10:5], rs2, rs1, f3, w[4:1], w[11], 7'h63};
            e.imm = w; e.c_imm = 1'b1; e.br = 1'b1; e.rd = 5'd0;
            e.c_rs1 = 1'b1; e.c_rs2 = 1'b1;
         end
         K_LOAD: begin
            e.inst = {v[11:0], rs1, f3, rd, 7'h03};
            e.imm = v; e.c_imm = 1'b1; e.c_rs1 = 1'b1;
            e.mre = 1'b1; e.we = 1'b1;
         end
         K_STORE: begin
            e.inst = {v[11:5], rs2, rs1, f3, v[4:0], 7'h23};
            e.imm = v; e.c_imm = 1'b1; e.rd = 5'd0;
            e.c_rs1 = 1'b1; e.c_rs2 = 1'b1; e.mwe = 1'b1;
         end
         K_MULDIV: begin
            e.inst = {7'h01, rs2, rs1, f3, rd, 7'h33};
`ifdef DECODE_MULDIV_EN
            e.aluop = ref_md(f3); e.c_alu = 1'b1;
            e.m1 = m1_rs1_out; e.m2 = m2_rs2_out;
            e.c_m1 = 1'b1; e.c_m2 = 1'b1;
            e.c_rs1 = 1'b1; e.c_rs2 = 1'b1;
            e.md = 1'b1; e.we = 1'b1;
`else
            e.ill = 1'b1; e.aluop = alu_op_none;
            e.c_alu = 1'b1; e.c_rd = 1'b0;
`endif
         end
         default: begin
            if (alt) e.inst = {7'h02, rs2, rs1, f3, rd, 7'h33};
            else e.inst = {v[24:0], 7'h7F};
            e.ill = 1'b1; e.aluop = alu_op_none;
            e.c_alu = 1'b1; e.c_rd = 1'b0;
         end
      endcase
      if (e.rd == 5'd0) e.we = 1'b0;
      return e;
   endfunction

   function automatic exp_t rnd_item();
      int kind;
      logic [31:0] r, v;
      logic [2:0] f3;
      logic alt;
      logic [2:0] brf [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
      logic [2:0] ldf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      kind = int'($urandom_range(0, 10));
      r = $urandom;
      f3 = 3'($urandom_range(0, 7));
      alt = 1'($urandom_range(0, 1));
      v = {{20{r[11]}}, r[11:0]};
      case (kind)
         K_LUI, K_AUIPC, K_BAD: v = r;
         K_JAL: v = {{11{r[20]}}, r[20:0]};
         K_BR: begin
            v = {{19{r[12]}}, r[12:0]};
            f3 = brf[$urandom_range(0, 5)];
         end
         K_LOAD: f3 = ldf[$urandom_range(0, 4)];
         K_STORE: f3 = 3'($urandom_range(0, 2));
         K_REG: if (f3 != 3'd0 && f3 != 3'd5) alt = 1'b0;
         default: ;
      endcase
      return enc(kind, 5'($urandom), 5'($urandom), 5'($urandom),
                 f3, alt, v);
   endfunction

   task automatic check_lane(input int i, input exp_t e);
      id_dis_stage_reg_t d;
      d = out_data[i];
      chk($sformatf("l%0d.inst", i), 64'(d.inst), 64'(e.inst));
      chk($sformatf("l%0d.pc", i), 64'(d.pc), 64'(e.pc));
      chk($sformatf("l%0d.order", i), d.order, e.order);
      if (e.c_rs1) chk($sformatf("l%0d.rs1", i), 64'(d.rs1_addr), 64'(e.rs1));
      if (e.c_rs2) chk($sformatf("l%0d.rs2", i), 64'(d.rs2_addr), 64'(e.rs2));
      if (e.c_rd) chk($sformatf("l%0d.rd", i), 64'(d.rd_addr), 64'(e.rd));
      if (e.c_imm) chk($sformatf("l%0d.imm", i), 64'(d.imm), 64'(e.imm));
      if (e.c_alu) chk($sformatf("l%0d.aluop", i), 64'(d.aluop), 64'(e.aluop));
      if (e.c_m1) chk($sformatf("l%0d.m1", i), 64'(d.alu_m1_sel), 64'(e.m1));
      if (e.c_m2) chk($sformatf("l%0d.m2", i), 64'(d.alu_m2_sel), 64'(e.m2));
      chk($sformatf("l%0d.we", i), 64'(d.regf_we), 64'(e.we));
      chk($sformatf("l%0d.mre", i), 64'(d.mem_re), 64'(e.mre));
      chk($sformatf("l%0d.mwe", i), 64'(d.mem_we), 64'(e.mwe));
      chk($sformatf("l%0d.ill", i), 64'(d.illegal), 64'(e.ill));
      chk($sformatf("l%0d.md", i), 64'(d.is_muldiv), 64'(e.md));
      if (!e.ill) begin
         chk($sformatf("l%0d.br", i), 64'(d.is_branch), 64'(e.br));
         chk($sformatf("l%0d.jmp", i), 64'(d.is_jump), 64'(e.jmp));
      end
   endtask

   task automatic check_all();
      int n;
      n = mdl.size();
      chk("occupancy", 64'(occupancy), 64'(n));
      chk("enq_ready", 64'(enq_ready), 64'(n != DEPTH));
      for (int i = 0; i < DW; i++) begin
         chk($sformatf("out_valid%0d", i), 64'(out_valid[i]), 64'(i < n));
         if (i < n) check_lane(i, mdl[i]);
      end
   endtask

   // Called at a negedge; applies one cycle of stimulus, then checks.
   task automatic cyc(input logic ev, input exp_t e_in, input logic dv,
                      input int acc, input logic fl);
      exp_t e;
      int k;
      logic fire;
      e = e_in;
      e.order = ord_ctr;
      e.pc = 32'h1000 + 4 * ord_ctr[31:0];
      if (ev) ord_ctr++;
      enq_valid = ev;
      enq_data.inst = e.inst;
      enq_data.pc = e.pc;
      enq_data.order = e.order;
      enq_data.valid = dv;
      dis_accept = AW'(acc);
      flush = fl;
      fire = ev && dv && (mdl.size() != DEPTH);
      k = (acc < mdl.size()) ? acc : mdl.size();
      @(posedge clk);
      if (fl) mdl.delete();
      else begin
         repeat (k) void'(mdl.pop_front());
         if (fire) mdl.push_back(e);
      end
      @(negedge clk);
      check_all();
   endtask

   initial begin
      int n, lim;
      rst = 1'b1; flush = 1'b0; enq_valid = 1'b0;
      enq_data = '0; dis_accept = '0;
      repeat (2) @(negedge clk);
      check_all();
      rst = 1'b0;
      @(negedge clk);
      check_all();

      // lui x1,0x12345 at pc 0x1000
      cyc(1, enc(K_LUI, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345000), 1, 0, 0);
      chk("lui.out_valid", 64'(out_valid), 64'(2'b01));
      chk("lui.imm", 64'(out_data[0].imm), 64'h12345000);
      chk("lui.pc", 64'(out_data[0].pc), 64'h1000);
      cyc(0, '0, 0, 1, 0);

      // fill to full, then dequeue 2 while fetch still pushes
      for (int i = 0; i < DEPTH; i++) cyc(1, rnd_item(), 1, 0, 0);
      chk("full.enq_ready", 64'(enq_ready), 64'd0);
      cyc(1, rnd_item(), 1, 2, 0);
      chk("after_deq.occ", 64'(occupancy), 64'd6);
      chk("after_deq.ready", 64'(enq_ready), 64'd1);

      // steady stream across pointer wrap
      for (int i = 0; i < 20; i++) cyc(1, rnd_item(), 1, 1, 0);
      chk("steady.occ", 64'(occupancy), 64'd6);

      // flush at occupancy 5 with a concurrent enqueue and dequeue
      cyc(0, '0, 0, 0, 1);
      for (int i = 0; i < 5; i++) cyc(1, rnd_item(), 1, 0, 0);
      cyc(1, rnd_item(), 1, 1, 1);
      chk("flush.occ", 64'(occupancy), 64'd0);
      chk("flush.out_valid", 64'(out_valid), 64'd0);

      // beq x1,x2,-8 / opcode 0x7F / mul x3,x1,x2 / non-valid fetch
      cyc(1, enc(K_BR, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFF_FFF8), 1, 0, 0);
      chk("beq.inst", 64'(out_data[0].inst), 64'hFE208CE3);
      chk("beq.imm", 64'(out_data[0].imm), 64'hFFFF_FFF8);
      cyc(1, enc(K_BAD, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0), 1, 0, 0);
      cyc(1, enc(K_MULDIV, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0), 1, 1, 0);
      cyc(1, enc(K_BAD, 5'd4, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0), 1, 1, 0);
      cyc(1, rnd_item(), 0, 0, 0);
      cyc(0, '0, 0, 1, 0);

      // random traffic
      for (int c = 0; c < 400; c++) begin
         n = mdl.size();
         lim = (n < DW) ? n : DW;
         cyc(($urandom % 4) != 0, rnd_item(), ($urandom % 10) != 0,
             int'($urandom_range(0, lim)), ($urandom % 32) == 0);
      end

      // asynchronous reset between clock edges
      for (int i = 0; i < 3; i++) cyc(1, rnd_item(), 1, 0, 0);
      enq_valid = 1'b0; dis_accept = '0; flush = 1'b0;
      #2 rst = 1'b1;
      #1 mdl.delete();
      check_all();
      @(negedge clk);
      check_all();
      rst = 1'b0;
      @(negedge clk);
      check_all();
      cyc(1, rnd_item(), 1, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
